// File: rtl/trail_compositor.sv
// -----------------------------------------------------------------------------
// trail_compositor
//
// Per-pixel compositor between the packed trail framebuffer and the palette
// stage. For every visible pixel it fetches the framebuffer word holding that
// pixel, picks out the pixel's PIX_BITS-wide colour, and overlays one sprite
// layer per player. Lower player indices are drawn on top. The block also
// detects when a bike lands on a trail or on another bike. Those hits are
// accumulated per player during the frame and published at every frame_clk
// rising edge.
//
// Pipeline (one pixel per cycle):
//   stage A  : address generation, capture of nibble index / sprites
//   delay    : RAM_LATENCY stages, aligns the captured fields with ram_data
//   select   : nibble extraction from the returned word
//   output   : colour priority mux, collision accumulation
//
// Ports:
//   Clk, Reset     system clock, synchronous active-high reset
//   frame_clk      ~60 Hz frame strobe, asynchronous to Clk
//   pix_valid      DrawX / DrawY / bike_px are valid this cycle
//   DrawX, DrawY   pixel column / row
//   bike_px        player p sprite colour at [p*PIX_BITS +: PIX_BITS]
//   trail_color    player p trail colour, same packing
//   ram_addr       framebuffer read address
//   ram_data       framebuffer read data, RAM_LATENCY cycles after ram_addr
//   color_enum     composited colour, holds while color_valid is low
//   color_valid    color_enum carries a new pixel this cycle
//   collide_live   sticky per-player hits in the current frame
//   collide_frame  per-player hits of the last completed frame
//   frame_done     one-cycle pulse when collide_frame is updated
// -----------------------------------------------------------------------------
module trail_compositor #(
    parameter int NUM_PLAYERS = 2,
    parameter int PIX_BITS    = 4,
    parameter int WORD_BITS   = 16,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19,
    parameter int BG_COLOR    = 0,
    parameter int TRANSPARENT = 15,
    parameter int RAM_LATENCY = 1,
    parameter int SELF_HIT    = 0
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            frame_clk,
    input  logic                            pix_valid,
    input  logic [9:0]                      DrawX,
    input  logic [9:0]                      DrawY,
    input  logic [NUM_PLAYERS*PIX_BITS-1:0] bike_px,
    input  logic [NUM_PLAYERS*PIX_BITS-1:0] trail_color,
    output logic [ADDR_W-1:0]               ram_addr,
    input  logic [WORD_BITS-1:0]            ram_data,
    output logic [PIX_BITS-1:0]             color_enum,
    output logic                            color_valid,
    output logic [NUM_PLAYERS-1:0]          collide_live,
    output logic [NUM_PLAYERS-1:0]          collide_frame,
    output logic                            frame_done
);

    localparam int PPW       = WORD_BITS / PIX_BITS;
    localparam int PPW_LOG   = $clog2(PPW);
    localparam int K_W       = (PPW > 1) ? PPW_LOG : 1;
    localparam int ROW_WORDS = H_RES / PPW;
    localparam int BIKE_W    = NUM_PLAYERS * PIX_BITS;
    localparam int LAST      = RAM_LATENCY - 1;

    localparam logic [PIX_BITS-1:0] BG    = PIX_BITS'(BG_COLOR);
    localparam logic [PIX_BITS-1:0] CLEAR = PIX_BITS'(TRANSPARENT);

    // Fields that travel alongside the RAM read.
    typedef struct packed {
        logic              oor;   // pixel outside the active area
        logic [K_W-1:0]    k;     // pixel slot inside the framebuffer word
        logic [BIKE_W-1:0] bike;  // sprite colours of all players
    } pix_t;

    // ------------------------------------------------------------------
    // Stage A inputs
    // ------------------------------------------------------------------
    logic [31:0] x32;
    logic [31:0] y32;
    logic        in_range;

    assign x32      = {22'd0, DrawX};
    assign y32      = {22'd0, DrawY};
    assign in_range = (x32 < H_RES) && (y32 < V_RES);

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                   a_valid;
    logic [LAST:0]          d_valid;
    logic                   s_valid;
    pix_t                   a_pix;
    pix_t                   d_pix [RAM_LATENCY];
    logic                   s_oor;
    logic [PIX_BITS-1:0]    s_trail;
    logic [BIKE_W-1:0]      s_bike;

    // Valids and the address are control state and must reset cleanly.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            a_valid  <= 1'b0;
            d_valid  <= '0;
            s_valid  <= 1'b0;
            ram_addr <= '0;
        end else begin
            a_valid    <= pix_valid;
            d_valid[0] <= a_valid;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                d_valid[i] <= d_valid[i-1];
            end
            s_valid <= d_valid[LAST];
            // Out-of-range pixels leave the address alone.
            if (pix_valid && in_range) begin
                ram_addr <= ADDR_W'(y32 * ROW_WORDS + (x32 >> PPW_LOG));
            end
        end
    end

    // NOTE: the datapath fields have no reset; the valid bits above already
    // mark them meaningless, so a reset here would only add fan-out.
    always_ff @(posedge Clk) begin
        if (pix_valid) begin
            a_pix.oor  <= !in_range;
            a_pix.k    <= K_W'(x32 & 32'(PPW - 1));
            a_pix.bike <= bike_px;
        end
        d_pix[0] <= a_pix;
        for (int i = 1; i < RAM_LATENCY; i++) begin
            d_pix[i] <= d_pix[i-1];
        end
        s_oor   <= d_pix[LAST].oor;
        s_trail <= PIX_BITS'(ram_data >> (d_pix[LAST].k * PIX_BITS));
        s_bike  <= d_pix[LAST].bike;
    end

    // ------------------------------------------------------------------
    // Colour priority and collision detection
    // ------------------------------------------------------------------
    logic [NUM_PLAYERS-1:0] bike_on;
    logic [NUM_PLAYERS-1:0] trail_hit;
    logic [NUM_PLAYERS-1:0] bike_hit;
    logic [NUM_PLAYERS-1:0] hit;
    logic [PIX_BITS-1:0]    next_color;

    // NOTE: every variable gets a default before the loops, so no path
    // through this block can leave a value held and infer a latch.
    always_comb begin
        bike_on    = '0;
        trail_hit  = '0;
        bike_hit   = '0;
        hit        = '0;
        next_color = s_trail;

        for (int p = 0; p < NUM_PLAYERS; p++) begin
            bike_on[p] = (s_bike[p*PIX_BITS +: PIX_BITS] != CLEAR);
        end

        for (int p = 0; p < NUM_PLAYERS; p++) begin
            // A player's own trail is harmless unless SELF_HIT is set.
            // Trail hits are not evaluated outside the active area.
            trail_hit[p] = !s_oor && (s_trail != BG) &&
                           ((SELF_HIT != 0) ||
                            (s_trail != trail_color[p*PIX_BITS +: PIX_BITS]));
            bike_hit[p]  = |(bike_on & ~(NUM_PLAYERS'(1) << p));
            hit[p]       = s_valid && bike_on[p] && (trail_hit[p] || bike_hit[p]);
        end

        // Walk downwards so the lowest-index visible sprite wins.
        for (int p = NUM_PLAYERS - 1; p >= 0; p--) begin
            if (bike_on[p]) begin
                next_color = s_bike[p*PIX_BITS +: PIX_BITS];
            end
        end
        if (s_oor) begin
            next_color = BG;
        end
    end

    // ------------------------------------------------------------------
    // frame_clk synchroniser and edge detect
    // ------------------------------------------------------------------
    logic       sync_1;
    logic       sync_2;
    logic       sync_hist;
    logic [1:0] sync_fill;
    logic       tick;

    // The history flop stays at its reset value of 1 until the synchroniser
    // has been refilled from frame_clk. A level that is already high when
    // reset is released is therefore not taken as an edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_hist <= 1'b1;
            sync_fill <= 2'b00;
        end else begin
            sync_1    <= frame_clk;
            sync_2    <= sync_1;
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1]) begin
                sync_hist <= sync_2;
            end
        end
    end

    assign tick = sync_2 && !sync_hist;

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_enum    <= '0;
            color_valid   <= 1'b0;
            collide_live  <= '0;
            collide_frame <= '0;
            frame_done    <= 1'b0;
        end else begin
            color_valid <= s_valid;
            if (s_valid) begin
                color_enum <= next_color;
            end
            frame_done <= tick;
            // A hit on the tick cycle still belongs to the closing frame.
            if (tick) begin
                collide_frame <= collide_live | hit;
                collide_live  <= '0;
            end else begin
                collide_live <= collide_live | hit;
            end
        end
    end

endmodule

// File: tb/tb_trail_compositor.sv
// -----------------------------------------------------------------------------
// tb_trail_compositor
//
// Directed bench for trail_compositor. Two instances share all stimulus: one
// with SELF_HIT=0 and one with SELF_HIT=1. Each instance has its own
// one-cycle RAM model. Expected colours are queued when a pixel is driven.
// A monitor pops them when color_valid appears and also checks the arrival
// edge against the expected latency.
// -----------------------------------------------------------------------------
module tb_trail_compositor;

    localparam int NP  = 2;
    localparam int PB  = 4;
    localparam int AW  = 19;
    localparam int RL  = 1;
    localparam int LAT = RL + 2;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           frame_clk;
    logic           pix_valid;
    logic [9:0]     DrawX;
    logic [9:0]     DrawY;
    logic [NP*PB-1:0] bike_px;
    logic [NP*PB-1:0] trail_color;

    logic [AW-1:0]  ram_addr0, ram_addr1;
    logic [15:0]    ram_data0, ram_data1;
    logic [PB-1:0]  color0, color1;
    logic           cv0, cv1;
    logic [NP-1:0]  live0, live1, frm0, frm1;
    logic           fd0, fd1;

    always #5 Clk = ~Clk;

    trail_compositor #(.SELF_HIT(0), .RAM_LATENCY(RL)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .bike_px(bike_px), .trail_color(trail_color),
        .ram_addr(ram_addr0), .ram_data(ram_data0), .color_enum(color0),
        .color_valid(cv0), .collide_live(live0), .collide_frame(frm0),
        .frame_done(fd0)
    );

    trail_compositor #(.SELF_HIT(1), .RAM_LATENCY(RL)) u_dut1 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .pix_valid(pix_valid),
        .DrawX(DrawX), .DrawY(DrawY), .bike_px(bike_px), .trail_color(trail_color),
        .ram_addr(ram_addr1), .ram_data(ram_data1), .color_enum(color1),
        .color_valid(cv1), .collide_live(live1), .collide_frame(frm1),
        .frame_done(fd1)
    );

    // Framebuffer model, one-cycle read latency. Unwritten words read as 0.
    logic [15:0] mem [int];

    always @(posedge Clk) begin
        ram_data0 <= mem.exists(int'(ram_addr0)) ? mem[int'(ram_addr0)] : 16'h0000;
        ram_data1 <= mem.exists(int'(ram_addr1)) ? mem[int'(ram_addr1)] : 16'h0000;
    end

    int edge_cnt = 0;
    always @(posedge Clk) edge_cnt++;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_pulses = 0;
    int fd_base;

    typedef struct {
        logic [PB-1:0] color;
        int            edge_no;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer. Sampling at the falling edge keeps reads away
    // from the active edge.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (fd0) fd_pulses++;
            if (cv0) begin
                if (q0.size() == 0) begin
                    check("dut0_stray_valid", 32'(cv0), 0);
                end else begin
                    e0 = q0.pop_front();
                    check("dut0_color", 32'(color0), 32'(e0.color));
                    check("dut0_latency", edge_cnt, e0.edge_no);
                end
            end
            if (cv1) begin
                if (q1.size() == 0) begin
                    check("dut1_stray_valid", 32'(cv1), 0);
                end else begin
                    e1 = q1.pop_front();
                    check("dut1_color", 32'(color1), 32'(e1.color));
                    check("dut1_latency", edge_cnt, e1.edge_no);
                end
            end
        end
    end

    // Called just after a falling edge. The pixel is sampled on the next
    // rising edge, and its colour is due LAT edges after that.
    task automatic drive_pix(input int x, input int y, input logic [NP*PB-1:0] bikes,
                             input logic [PB-1:0] exp_color);
        pix_valid = 1'b1;
        DrawX     = 10'(x);
        DrawY     = 10'(y);
        bike_px   = bikes;
        q0.push_back('{exp_color, edge_cnt + 1 + LAT});
        q1.push_back('{exp_color, edge_cnt + 1 + LAT});
        @(negedge Clk);
        pix_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) begin
            @(negedge Clk);
        end
        @(negedge Clk);
        check("sb_drain", q0.size() + q1.size(), 0);
    endtask

    // Raise frame_clk and check the frame_done pulse on the third rising
    // edge, together with the published and cleared collision vectors.
    task automatic frame_tick(input logic [NP-1:0] exp0, input logic [NP-1:0] exp1);
        frame_clk = 1'b1;
        @(negedge Clk); check("tick_fd_e1", 32'(fd0), 0);
        @(negedge Clk); check("tick_fd_e2", 32'(fd0), 0);
        @(negedge Clk);
        check("tick_fd_e3",   32'(fd0), 1);
        check("tick_frame0",  32'(frm0), 32'(exp0));
        check("tick_frame1",  32'(frm1), 32'(exp1));
        check("tick_live0",   32'(live0), 0);
        check("tick_live1",   32'(live1), 0);
        @(negedge Clk); check("tick_fd_e4", 32'(fd0), 0);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        Reset       = 1'b1;
        frame_clk   = 1'b0;
        pix_valid   = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        bike_px     = 8'hFF;
        trail_color = 8'h93;          // player1 trail 9, player0 trail 3
        mem[0]      = 16'h3210;
        mem[1]      = 16'h8880;
        mem[321]    = 16'h00A0;

        repeat (3) @(negedge Clk);
        check("rst_addr",  32'(ram_addr0), 0);
        check("rst_color", 32'(color0), 0);
        check("rst_valid", 32'(cv0), 0);
        check("rst_live",  32'(live0), 0);
        check("rst_frame", 32'(frm0), 0);
        check("rst_fd",    32'(fd0), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Nibble walk across word 0.
        drive_pix(0, 0, 8'hFF, 4'h0);
        check("t1_addr", 32'(ram_addr0), 0);
        for (int x = 1; x < 4; x++) begin
            drive_pix(x, 0, 8'hFF, PB'(x));
        end
        drain();

        // Address arithmetic: 2*160 + 5/4 = 321, slot 1.
        drive_pix(5, 2, 8'hFF, 4'hA);
        check("t2_addr", 32'(ram_addr0), 321);
        drain();
        repeat (2) @(negedge Clk);
        check("hold_addr",  32'(ram_addr0), 321);
        check("hold_color", 32'(color0), 32'hA);
        check("hold_valid", 32'(cv0), 0);

        // Player0 on its own trail colour.
        drive_pix(3, 0, {4'hF, 4'h7}, 4'h7);
        drain();
        check("t3_live_noself", 32'(live0), 0);
        check("t3_live_self",   32'(live1), 32'h1);

        // Bike-on-bike over background.
        drive_pix(4, 0, {4'h6, 4'h5}, 4'h5);
        drain();
        check("t4_live0", 32'(live0), 32'h3);
        check("t4_live1", 32'(live1), 32'h3);

        // Close the frame so the following checks start clean.
        frame_tick(2'b11, 2'b11);

        // Player1 on a foreign trail (8 vs own 9).
        drive_pix(5, 0, {4'h2, 4'hF}, 4'h2);
        drain();
        check("t5_live0", 32'(live0), 32'h2);
        frame_tick(2'b10, 2'b10);
        frame_tick(2'b00, 2'b00);

        // Out of range: background colour, address held, no trail hit.
        drive_pix(701, 0, {4'hF, 4'h7}, 4'h0);
        drive_pix(1, 480, {4'hF, 4'h7}, 4'h0);
        drain();
        check("oor_addr",  32'(ram_addr0), 1);
        check("oor_live0", 32'(live0), 0);
        check("oor_live1", 32'(live1), 0);
        // Bike-on-bike is still reported off screen.
        drive_pix(702, 0, {4'h6, 4'h5}, 4'h0);
        drain();
        check("oor_bikes", 32'(live0), 32'h3);

        // Reset with pixels in flight and frame_clk held high.
        pix_valid = 1'b1;
        DrawX     = 10'd0;
        DrawY     = 10'd0;
        bike_px   = 8'hFF;
        @(negedge Clk);
        DrawX = 10'd1;
        @(negedge Clk);
        Reset     = 1'b1;
        frame_clk = 1'b1;
        pix_valid = 1'b0;
        repeat (3) @(negedge Clk);
        check("t6_addr",  32'(ram_addr0), 0);
        check("t6_color", 32'(color0), 0);
        check("t6_valid", 32'(cv0), 0);
        check("t6_live",  32'(live0), 0);
        check("t6_frame", 32'(frm0), 0);
        check("t6_fd",    32'(fd0), 0);
        fd_base = fd_pulses;
        Reset = 1'b0;
        repeat (12) @(negedge Clk);
        check("t6_no_frame_done", fd_pulses - fd_base, 0);
        check("t6_live_after",    32'(live0), 0);
        check("final_drain", q0.size() + q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trail_compositor.md
Name: trail_compositor

Overview:
- Per-pixel compositor between the packed 4-bit-per-pixel trail framebuffer and the VGA palette stage.
- For each visible pixel it reads the trail word, selects the pixel's nibble and overlays NUM_PLAYERS bike sprite layers.
- It flags bike-on-trail and bike-on-bike collisions per player, accumulating them during the frame and publishing them at each frame_clk boundary.
- Successor to the fixed two-player combinational compositor: parametrised packing and player count, a pipelined RAM read, and frame-latched collision flags.

Parameters:
NUM_PLAYERS, 2, number of bike layers/players (1..4)
PIX_BITS, 4, bits per colour enum
WORD_BITS, 16, framebuffer word width; PPW = WORD_BITS/PIX_BITS, power of two
H_RES, 640, active width; divisible by PPW
V_RES, 480, active height
ADDR_W, 19, framebuffer read address width
BG_COLOR, 0, empty-trail enum
TRANSPARENT, 15, bike-layer "no sprite" enum
RAM_LATENCY, 1, framebuffer read latency in cycles (1..2)
SELF_HIT, 0, 1 = a player's own trail colour counts as a collision

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_clk  in  1  ~60 Hz frame strobe, asynchronous to Clk
pix_valid  in  1  DrawX/DrawY/bike_px are valid this cycle
DrawX  in  10  pixel column
DrawY  in  10  pixel row
bike_px  in  NUM_PLAYERS*PIX_BITS  player p sprite enum at [p*PIX_BITS +: PIX_BITS]
trail_color  in  NUM_PLAYERS*PIX_BITS  player p trail enum, same packing
ram_addr  out  ADDR_W  framebuffer read address
ram_data  in  WORD_BITS  framebuffer read data
color_enum  out  PIX_BITS  composited colour
color_valid  out  1  color_enum valid
collide_live  out  NUM_PLAYERS  sticky hits so far this frame
collide_frame  out  NUM_PLAYERS  hits of the last completed frame
frame_done  out  1  one-cycle pulse at frame boundary

Behaviour:
- Reset: every output is 0. Pipeline valids are cleared. frame_clk synchroniser flops reset to 0; the edge-detect history flop resets to 1, so no tick is generated on reset release.
- Stage A (registered on the edge where pix_valid=1):
  - ram_addr <= DrawY*(H_RES/PPW) + DrawX/PPW, truncated to ADDR_W.
  - Also capture the nibble index k = DrawX mod PPW, plus bike_px and valid.
- Delay line: captured fields are delayed RAM_LATENCY cycles to align with ram_data.
- Stage B (output register):
  - trail = ram_data[k*PIX_BITS +: PIX_BITS].
  - color_enum = bike enum of the lowest-index player p whose bike_px != TRANSPARENT; otherwise trail.
- Latency: pix_valid at edge N gives color_valid=1 at edge N+RAM_LATENCY+2, throughput 1 pixel/cycle.
  - When pix_valid=0, color_valid=0 and ram_addr holds its value.
  - color_enum holds its last value while invalid.
- Out of range (DrawX >= H_RES or DrawY >= V_RES with pix_valid=1):
  - ram_addr holds, color_enum=BG_COLOR, color_valid=1.
  - No trail collision is evaluated; bike-bike overlap is still evaluated.
- Collision for player p at stage B (valid pixel, bike_px[p] != TRANSPARENT):
  - trail hit: trail != BG_COLOR, and (SELF_HIT=1 or trail != trail_color[p]);
  - bike hit: any other player q has bike_px[q] != TRANSPARENT.
  - hit[p] = trail hit OR bike hit. Both players of an overlapping pair are flagged.
- collide_live[p] <= collide_live[p] | hit[p] every cycle.
- Frame tick: frame_clk passes through a 2-flop synchroniser; tick = sync high AND history low.
  - On tick: collide_frame <= collide_live | hit, collide_live <= 0, frame_done=1 for that cycle. A hit on the tick cycle belongs to the closing frame.
- Reset mid-frame clears everything and drops in-flight pixels; no color_valid appears for them.

Test Plan:
1. RAM model 1-cycle read, word at addr 0 = 16'h3210, no bikes; pix_valid with DrawX=0..3, DrawY=0 → ram_addr=0 and color_enum 0,1,2,3 on edges 3..6 after the first sample.
2. DrawX=5, DrawY=2, PPW=4 → ram_addr=321, nibble 1 selected.
3. ram_data nibble=3, player0 bike_px=7, trail_color0=3:
   - SELF_HIT=0 → color_enum=7, collide_live=2'b00;
   - SELF_HIT=1 → collide_live[0]=1.
4. Both bikes non-transparent (5, 6) on a BG pixel → color_enum=5, collide_live=2'b11.
5. Player1 hits trail, then frame_clk rises → frame_done pulses once at the 3rd Clk edge after the rise; collide_frame=2'b10, collide_live=0; a second tick with no hits → collide_frame=0.
6. Reset asserted with frame_clk held high and pixels in flight → all outputs 0, no frame_done after release, no stray color_valid.
